// File: rtl/uart_rx_pkg.sv
// Shared types for the parametrised UART receiver: FSM states, FIFO word
// layout and the parity helper.
package uart_rx_pkg;

  // Widest data field a FIFO word can carry; DATA_WIDTH of the top must not exceed it.
  localparam int unsigned RX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic                     brk;
    logic                     ferr;
    logic                     perr;
    logic [RX_DATA_WIDTH-1:0] data;
  } rx_word_t;

  // Parity bit that makes the total ones count even (even=1) or odd (even=0).
  // Unused upper data bits are zero, so reducing the whole field is safe.
  function automatic logic parity_bit(input logic [RX_DATA_WIDTH-1:0] d, input logic even);
    return (^d) ^ ~even;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO of rx_word_t. A push into a full FIFO
// is dropped and reported by a one-cycle overrun pulse, unless a pop frees
// the slot in the same cycle.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push,
  input  rx_word_t                 push_word,
  input  logic                     pop,
  output rx_word_t                 head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  rx_word_t          mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers, occupancy and the overrun strobe
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      overrun <= push & ~do_push;
    end
  end

  // Storage array; contents need no reset because level gates visibility
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: RX synchroniser, 3-sample majority vote,
// run-time frame format, break detection, FWFT receive FIFO.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | line idle, waiting for a low sample on rx_tick
//   START    | validating start bit; majority high at mid-bit = false start
//   DATA     | shifting in the latched number of data bits, LSB first
//   PARITY   | sampling the parity bit
//   STOP1    | first stop bit; pushes here for 1-stop frames or breaks
//   STOP2    | second stop bit; pushes at mid-bit
//   BRK_WAIT | after a break, waiting for one full bit time of line high
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 9,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          rx_tick,
  input  logic                          RX,
  input  logic                          rx_enable,
  input  logic [3:0]                    frame_length,
  input  logic [1:0]                    parity,
  input  logic                          stop_bit,
  input  logic                          rx_pop,
  output logic [DATA_WIDTH-1:0]         rx_data_out,
  output logic                          rx_valid,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned M  = OVERSAMPLE / 2;
  // tick_rem counts down through the bit; tick count k in the bit has tick_rem = OVERSAMPLE-1-k
  localparam logic [TW-1:0] T_RELOAD = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_FIRST  = TW'(OVERSAMPLE - 2);
  localparam logic [TW-1:0] T_S0     = TW'(OVERSAMPLE - M);
  localparam logic [TW-1:0] T_S1     = TW'(OVERSAMPLE - M - 1);
  localparam logic [TW-1:0] T_S2     = TW'(OVERSAMPLE - M - 2);
  localparam logic [3:0]    LEN_MIN  = 4'd5;
  localparam logic [3:0]    LEN_MAX  = 4'(DATA_WIDTH);

  rx_state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rxs;
  logic [TW-1:0]           tick_rem;
  logic [3:0]              bit_rem;
  logic [3:0]              bit_idx;
  logic [3:0]              len_q;
  logic                    par_en_q, par_even_q, two_stop_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    perr_q, ferr_q, par_smp_q;
  logic [1:0]              samp_q;
  logic                    maj, at_mid, bit_end, is_break;
  logic                    push;
  rx_word_t                push_word;
  rx_word_t                head;
  logic                    fifo_empty;

  // RX synchroniser; flops reset to the idle level
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign maj      = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
  assign at_mid   = rx_tick && (tick_rem == T_S2);
  assign bit_end  = rx_tick && (tick_rem == '0);
  assign bit_idx  = len_q - 4'd1 - bit_rem;
  // A break is all-zero data, a low parity sample (if any) and a low first stop bit
  assign is_break = (data_q == '0) && (!par_en_q || !par_smp_q) && !maj;

  // FSM state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; dropping rx_enable aborts any frame in progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_tick && rx_enable && !rxs) state_d = START;
      START:    if (at_mid && maj) state_d = IDLE;
                else if (bit_end)  state_d = DATA;
      DATA:     if (bit_end && bit_rem == '0) state_d = par_en_q ? PARITY : STOP1;
      PARITY:   if (bit_end) state_d = STOP1;
      STOP1:    if (at_mid && is_break)     state_d = BRK_WAIT;
                else if (at_mid && !two_stop_q) state_d = IDLE;
                else if (bit_end)           state_d = STOP2;
      STOP2:    if (at_mid) state_d = IDLE;
      BRK_WAIT: if (rx_tick && rxs && tick_rem == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_q != IDLE && !rx_enable) state_d = IDLE;
  end

  // FSM outputs: FIFO push and the word to store
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      STOP1: if (at_mid && rx_enable) begin
        if (is_break) begin
          push           = 1'b1;
          push_word.brk  = 1'b1;
          push_word.ferr = 1'b1;
        end else if (!two_stop_q) begin
          push           = 1'b1;
          push_word.ferr = ferr_q | ~maj;
          push_word.perr = perr_q;
          push_word.data = RX_DATA_WIDTH'(data_q);
        end
      end
      STOP2: if (at_mid && rx_enable) begin
        push           = 1'b1;
        push_word.ferr = ferr_q | ~maj;
        push_word.perr = perr_q;
        push_word.data = RX_DATA_WIDTH'(data_q);
      end
      default: ;
    endcase
  end

  // Bit timing, sample history, config latch and frame assembly; advance on rx_tick only
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tick_rem   <= '0;
      bit_rem    <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      two_stop_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_smp_q  <= 1'b0;
      samp_q     <= '0;
    end else if (rx_tick) begin
      if (tick_rem == T_S0 || tick_rem == T_S1) samp_q <= {samp_q[0], rxs};
      case (state_q)
        IDLE: if (rx_enable && !rxs) begin
          tick_rem   <= T_FIRST;
          len_q      <= (frame_length < LEN_MIN) ? LEN_MIN :
                        (frame_length > LEN_MAX) ? LEN_MAX : frame_length;
          par_en_q   <= parity[1];
          par_even_q <= parity[0];
          two_stop_q <= stop_bit;
          data_q     <= '0;
          perr_q     <= 1'b0;
          ferr_q     <= 1'b0;
          par_smp_q  <= 1'b0;
        end
        BRK_WAIT: tick_rem <= (!rxs || tick_rem == '0) ? T_RELOAD : tick_rem - 1'b1;
        default: begin
          tick_rem <= (tick_rem == '0) ? T_RELOAD : tick_rem - 1'b1;
          case (state_q)
            START:  if (tick_rem == '0) bit_rem <= len_q - 4'd1;
            DATA: begin
              if (at_mid) data_q[bit_idx] <= maj;
              if (bit_end && bit_rem != '0) bit_rem <= bit_rem - 4'd1;
            end
            PARITY: if (at_mid) begin
              par_smp_q <= maj;
              perr_q    <= (maj != parity_bit(RX_DATA_WIDTH'(data_q), par_even_q));
            end
            STOP1:  if (at_mid) begin
              ferr_q <= ferr_q | ~maj;
              if (is_break) tick_rem <= T_RELOAD;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .push      (push),
    .push_word (push_word),
    .pop       (rx_pop),
    .head      (head),
    .empty     (fifo_empty),
    .level     (rx_level),
    .overrun   (rx_overrun)
  );

  assign rx_valid      = ~fifo_empty;
  assign rx_data_out   = head.data[DATA_WIDTH-1:0];
  assign rx_parity_err = head.perr;
  assign rx_frame_err  = head.ferr;
  assign rx_break      = head.brk;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param with a scoreboard of expected FIFO words.
module tb_uart_rx_param;
  import uart_rx_pkg::*;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       rx_tick = 1'b0;
  logic       RX = 1'b1;
  logic       rx_enable = 1'b1;
  logic [3:0] frame_length = 4'd8;
  logic [1:0] parity = 2'b00;
  logic       stop_bit = 1'b0;
  logic       rx_pop = 1'b0;
  logic [8:0] rx_data_out;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy;
  logic [3:0] rx_level;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int tick_div = 0;
  rx_word_t exp_q[$];

  uart_rx_param #(
    .DATA_WIDTH(9), .OVERSAMPLE(OS), .FIFO_DEPTH(8), .SYNC_STAGES(2)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .rx_tick(rx_tick), .RX(RX), .rx_enable(rx_enable),
    .frame_length(frame_length), .parity(parity), .stop_bit(stop_bit), .rx_pop(rx_pop),
    .rx_data_out(rx_data_out), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_break(rx_break), .rx_overrun(rx_overrun),
    .rx_level(rx_level), .rx_busy(rx_busy)
  );

  always #5 PCLK = ~PCLK;

  // Oversample strobe: one PCLK high every 4 PCLKs
  initial forever begin
    @(negedge PCLK);
    tick_div = (tick_div + 1) % 4;
    rx_tick = (tick_div == 0);
  end

  initial forever begin
    @(negedge PCLK);
    if (rx_overrun) ovr_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    @(posedge PCLK);
    while (rx_tick !== 1'b1) @(posedge PCLK);
    #1;
  endtask

  task automatic send_ticks(input logic v, input int n);
    RX = v;
    repeat (n) next_tick();
  endtask

  task automatic send_bit(input logic v);
    send_ticks(v, OS);
  endtask

  task automatic expect_word(input logic b, input logic f, input logic p, input logic [8:0] d);
    rx_word_t w;
    w.brk = b; w.ferr = f; w.perr = p; w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic send_frame(input logic [8:0] d, input int len, input logic [1:0] par,
                            input logic two, input logic flip_par, input int glitch,
                            input logic pop_at_push);
    logic pb;
    send_bit(1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == glitch) begin
        send_ticks(d[i], M);
        send_ticks(~d[i], 1);
        send_ticks(d[i], OS - M - 1);
      end else begin
        send_bit(d[i]);
      end
    end
    if (par[1]) begin
      pb = par[0] ? (^d) : ~(^d);
      send_bit(pb ^ flip_par);
    end
    if (pop_at_push) begin
      send_ticks(1'b1, M + 1);
      repeat (3) @(posedge PCLK);
      #1 rx_pop = 1'b1;
      @(posedge PCLK);
      #1 rx_pop = 1'b0;
      send_ticks(1'b1, OS - M - 2);
    end else begin
      send_bit(1'b1);
      if (two) send_bit(1'b1);
    end
  endtask

  task automatic pop_check(input string tag);
    rx_word_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_extra"}, 32'(rx_valid), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"},  32'(rx_data_out), 32'(e.data));
    chk({tag, "_brk"},   32'(rx_break), 32'(e.brk));
    chk({tag, "_ferr"},  32'(rx_frame_err), 32'(e.ferr));
    chk({tag, "_perr"},  32'(rx_parity_err), 32'(e.perr));
    rx_pop = 1'b1;
    @(posedge PCLK);
    #1 rx_pop = 1'b0;
    next_tick();
  endtask

  initial begin
    repeat (4) @(posedge PCLK);
    #1;
    chk("rst_busy_in_reset", 32'(rx_busy), 32'd0);
    PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data_out), 32'd0);
    chk("rst_level", 32'(rx_level), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_flags", 32'({rx_break, rx_frame_err, rx_parity_err}), 32'd0);
    next_tick();

    // 8N1 0xA5
    frame_length = 4'd8; parity = 2'b00; stop_bit = 1'b0;
    expect_word(1'b0, 1'b0, 1'b0, 9'h0A5);
    send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    chk("t1_level", 32'(rx_level), 32'd1);
    pop_check("t1");
    chk("t1_drained", 32'(rx_valid), 32'd0);

    // 7O2 back-to-back, bad parity on the second frame
    frame_length = 4'd7; parity = 2'b10; stop_bit = 1'b1;
    expect_word(1'b0, 1'b0, 1'b0, 9'h03C);
    expect_word(1'b0, 1'b0, 1'b1, 9'h041);
    send_frame(9'h03C, 7, 2'b10, 1'b1, 1'b0, -1, 1'b0);
    send_frame(9'h041, 7, 2'b10, 1'b1, 1'b1, -1, 1'b0);
    chk("t2_level", 32'(rx_level), 32'd2);
    pop_check("t2a");
    pop_check("t2b");

    // False start: 4 low ticks
    frame_length = 4'd8; parity = 2'b00; stop_bit = 1'b0;
    send_ticks(1'b0, 4);
    send_ticks(1'b1, 2);
    chk("t3_busy_start", 32'(rx_busy), 32'd1);
    send_ticks(1'b1, OS);
    chk("t3_busy_idle", 32'(rx_busy), 32'd0);
    chk("t3_level", 32'(rx_level), 32'd0);

    // Break at 8E1: 20 bit times low
    parity = 2'b11;
    expect_word(1'b1, 1'b1, 1'b0, 9'h000);
    send_ticks(1'b0, 20 * OS);
    chk("t4_level_break", 32'(rx_level), 32'd1);
    chk("t4_busy_wait", 32'(rx_busy), 32'd1);
    send_ticks(1'b1, M);
    chk("t4_busy_partial", 32'(rx_busy), 32'd1);
    send_ticks(1'b1, OS);
    chk("t4_busy_idle", 32'(rx_busy), 32'd0);
    chk("t4_level_hold", 32'(rx_level), 32'd1);
    expect_word(1'b0, 1'b0, 1'b0, 9'h05A);
    send_frame(9'h05A, 8, 2'b11, 1'b0, 1'b0, -1, 1'b0);
    chk("t4_level_after", 32'(rx_level), 32'd2);
    pop_check("t4brk");
    pop_check("t4nxt");

    // Overrun: nine frames into eight entries
    parity = 2'b00;
    for (int i = 0; i < 9; i++) begin
      logic [8:0] d;
      d = 9'((i * 29 + 3) % 256);
      if (i < 8) expect_word(1'b0, 1'b0, 1'b0, d);
      send_frame(d, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    end
    chk("t5_level_full", 32'(rx_level), 32'd8);
    chk("t5_overrun_once", 32'(ovr_cnt), 32'd1);
    chk("t5_head", 32'(rx_data_out), 32'(exp_q[0].data));
    void'(exp_q.pop_front());
    expect_word(1'b0, 1'b0, 1'b0, 9'h0E7);
    send_frame(9'h0E7, 8, 2'b00, 1'b0, 1'b0, -1, 1'b1);
    chk("t5_level_pushpop", 32'(rx_level), 32'd8);
    chk("t5_no_new_overrun", 32'(ovr_cnt), 32'd1);
    for (int i = 0; i < 8; i++) pop_check("t5");
    chk("t5_drained", 32'(rx_valid), 32'd0);

    // Single-sample glitch on bit 2
    expect_word(1'b0, 1'b0, 1'b0, 9'h096);
    send_frame(9'h096, 8, 2'b00, 1'b0, 1'b0, 2, 1'b0);
    pop_check("t6");

    // rx_enable abort mid-frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_ticks(1'b0, 3);
    rx_enable = 1'b0;
    @(posedge PCLK);
    #1;
    chk("t7_abort_busy", 32'(rx_busy), 32'd0);
    send_ticks(1'b1, OS);
    rx_enable = 1'b1;
    send_ticks(1'b1, OS);
    chk("t7_abort_level", 32'(rx_level), 32'd0);

    // Pop on empty, then frame-length clamping both ways
    rx_pop = 1'b1;
    @(posedge PCLK);
    #1 rx_pop = 1'b0;
    chk("t8_pop_empty", 32'(rx_level), 32'd0);
    next_tick();
    frame_length = 4'd3;
    expect_word(1'b0, 1'b0, 1'b0, 9'h015);
    send_frame(9'h015, 5, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    pop_check("t8min");
    frame_length = 4'd15;
    expect_word(1'b0, 1'b0, 1'b0, 9'h1C7);
    send_frame(9'h1C7, 9, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    pop_check("t8max");

    // PRESET mid-frame with a word already queued
    frame_length = 4'd8;
    expect_word(1'b0, 1'b0, 1'b0, 9'h033);
    send_frame(9'h033, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_ticks(1'b0, 5);
    RX = 1'b1;
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    chk("t9_level", 32'(rx_level), 32'd0);
    chk("t9_valid", 32'(rx_valid), 32'd0);
    chk("t9_data", 32'(rx_data_out), 32'd0);
    chk("t9_busy", 32'(rx_busy), 32'd0);
    PRESET = 1'b0;
    exp_q.delete();
    send_ticks(1'b1, 2 * OS);
    expect_word(1'b0, 1'b0, 1'b0, 9'h0C3);
    send_frame(9'h0C3, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    chk("t9_level_after", 32'(rx_level), 32'd1);
    pop_check("t9");
    chk("t9_drained", 32'(rx_valid), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed-format UART receiver. It runs on the APB clock with an oversampling tick enable and synchronises the RX line. Each bit is taken by 3-sample majority vote. Frame length, parity and stop bits are configurable at run time, and the block detects break conditions. Received words and their per-word status go into a first-word-fall-through (FWFT) FIFO, which the APB register block drains.

Parameters:
DATA_WIDTH, 9, maximum data bits per frame; the FIFO data field width.
OVERSAMPLE, 16, rx_tick strobes per bit period; even, >= 8.
FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2.
SYNC_STAGES, 2, RX synchroniser flops.

Ports:
PCLK  in  1  system clock; all logic on rising edge.
PRESET  in  1  asynchronous, active-high reset.
rx_tick  in  1  oversample strobe, one PCLK wide.
RX  in  1  serial line, asynchronous, idles high.
rx_enable  in  1  receiver enable.
frame_length  in  4  data bits per frame; legal 5..DATA_WIDTH.
parity  in  2  bit1 = enable; 2'b10 odd, 2'b11 even.
stop_bit  in  1  0 = one stop bit, 1 = two stop bits.
rx_pop  in  1  consume FIFO head.
rx_data_out  out  DATA_WIDTH  FIFO head data, LSB = first received bit; 0 when empty.
rx_valid  out  1  FIFO not empty.
rx_parity_err  out  1  head word parity error flag.
rx_frame_err  out  1  head word stop-bit error flag.
rx_break  out  1  head word is a break.
rx_overrun  out  1  one-PCLK pulse: word dropped because FIFO full.
rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
rx_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: FSM IDLE; FIFO empty; all outputs 0; synchroniser flops reset to 1; tick/bit counters 0.
- The synchronised RX (rxs) feeds the FSM. All counters advance only on cycles where rx_tick=1.
- Majority sample: value of rxs at tick counts M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three.
- IDLE: on rx_tick with rxs=0 and rx_enable=1, go to START. Latch frame_length (clamp <5 to 5, >DATA_WIDTH to DATA_WIDTH), parity and stop_bit. Mid-frame config changes are ignored.
- START: at tick M+1, majority=1 means false start: return to IDLE, nothing pushed. Otherwise, at tick OVERSAMPLE-1 go to DATA.
- DATA: shift in the latched frame length of bits, LSB first. Unused upper bits of the stored word are 0. After the last bit go to PARITY if enabled, else STOP1.
- PARITY: the expected bit makes the total count of ones odd (2'b10) or even (2'b11). A mismatch sets parity_err for this word.
- STOP1: majority=0 sets frame_err.
  - If stop_bit=1, go to STOP2 at bit end.
  - Otherwise push at tick M+1 and go straight to IDLE, so a back-to-back start is caught.
- STOP2: majority=0 sets frame_err. Push at tick M+1, then go to IDLE.
- Break: data all 0, parity sample 0 (if enabled) and first stop 0. Push the word with break=1, frame_err=1, data=0. Then go to BRK_WAIT, which leaves to IDLE only after rxs=1 has been seen at majority for one full bit time.
- rx_enable=0 in any state other than IDLE: abort within 1 PCLK to IDLE, discard the partial frame, FIFO untouched.
- FIFO entry: {break, frame_err, parity_err, data}. FWFT: head visible combinationally from the FIFO registers.
  - rx_pop while empty is ignored.
  - Push while full: word dropped, rx_overrun pulses.
  - Push and pop in the same cycle while full: both happen, level unchanged, no overrun.
- Pointers wrap modulo FIFO_DEPTH; level is kept separately (0..FIFO_DEPTH).
- Latency: rx_valid rises 1 PCLK after the push edge.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT);
  - the rx_word_t packed struct {brk, ferr, perr, data};
  - a function computing the parity bit.
- One sub-module, uart_rx_fifo: parametrised FWFT FIFO of rx_word_t, with push/pop, full/empty, level and the overrun pulse.
- FSM, synchroniser and majority vote stay in uart_rx_param.

Test Plan:
- 8N1, OVERSAMPLE=16, byte 8'hA5 -> one push; rx_data_out=9'h0A5, all error flags 0, rx_level=1; rx_pop -> rx_valid=0.
- 7O2 frames 7'h3C then 7'h41 back-to-back, with a wrong parity bit on the second -> two entries; the first is clean, the second has rx_parity_err=1 and data 9'h041.
- RX low pulse of 4 ticks, then high -> false start; no push, FSM back in IDLE, rx_busy low within 1 bit time.
- RX held low for 20 bit times at 8E1 -> exactly one entry with rx_break=1, rx_frame_err=1, data 0; no further pushes until RX is high for 1 bit.
- Nine frames into FIFO_DEPTH=8 with no pops -> rx_level=8 and one rx_overrun pulse. Then a pop coinciding with a 10th push -> level stays 8, no overrun.
- Single-tick glitch on one data bit sample (1 of 3 samples flipped) -> data unaffected. PRESET asserted mid-frame -> FIFO empty, outputs 0, and the next frame is received correctly.
